// File: rtl/exe_alu_branch_unit.sv
// Execute-stage ALU with architectural HI/LO registers and branch/jump resolution.
// alu_result and taken are combinational; HI/LO update on the rising clock edge.
module exe_alu_branch_unit (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [5:0]  alu_control,
    input  logic [4:0]  shift_amount,
    input  logic [31:0] instr,
    input  logic        jump,
    output logic [31:0] alu_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        taken
);

    localparam logic [5:0] OP_ADD   = 6'h01;
    localparam logic [5:0] OP_SUB   = 6'h02;
    localparam logic [5:0] OP_AND   = 6'h03;
    localparam logic [5:0] OP_OR    = 6'h04;
    localparam logic [5:0] OP_XOR   = 6'h05;
    localparam logic [5:0] OP_NOR   = 6'h06;
    localparam logic [5:0] OP_SLT   = 6'h07;
    localparam logic [5:0] OP_SLTU  = 6'h08;
    localparam logic [5:0] OP_SLL   = 6'h09;
    localparam logic [5:0] OP_SRL   = 6'h0A;
    localparam logic [5:0] OP_SRA   = 6'h0B;
    localparam logic [5:0] OP_SLLV  = 6'h0C;
    localparam logic [5:0] OP_SRLV  = 6'h0D;
    localparam logic [5:0] OP_SRAV  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_MULT  = 6'h10;
    localparam logic [5:0] OP_MULTU = 6'h11;
    localparam logic [5:0] OP_DIV   = 6'h12;
    localparam logic [5:0] OP_DIVU  = 6'h13;
    localparam logic [5:0] OP_MFHI  = 6'h14;
    localparam logic [5:0] OP_MFLO  = 6'h15;
    localparam logic [5:0] OP_MTHI  = 6'h16;
    localparam logic [5:0] OP_MTLO  = 6'h17;
    localparam logic [5:0] OP_PASSA = 6'h18;

    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic signed [63:0] a_s64, b_s64;
    logic [63:0]        a_u64, b_u64;
    logic [4:0]         var_sh;
    logic [5:0]         opcode;
    logic [4:0]         rt;
    logic               unused_instr_bits;

    assign a_s64  = {{32{op_a[31]}}, op_a};
    assign b_s64  = {{32{op_b[31]}}, op_b};
    assign a_u64  = {32'h0, op_a};
    assign b_u64  = {32'h0, op_b};
    assign var_sh = op_a[4:0];
    assign opcode = instr[31:26];
    assign rt     = instr[20:16];
    assign unused_instr_bits = ^{instr[25:21], instr[15:0]};

    always_comb begin
        alu_result = 32'h0;
        case (alu_control)
            OP_ADD:   alu_result = op_a + op_b;
            OP_SUB:   alu_result = op_a - op_b;
            OP_AND:   alu_result = op_a & op_b;
            OP_OR:    alu_result = op_a | op_b;
            OP_XOR:   alu_result = op_a ^ op_b;
            OP_NOR:   alu_result = ~(op_a | op_b);
            OP_SLT:   alu_result = {31'h0, $signed(op_a) < $signed(op_b)};
            OP_SLTU:  alu_result = {31'h0, op_a < op_b};
            OP_SLL:   alu_result = op_b << shift_amount;
            OP_SRL:   alu_result = op_b >> shift_amount;
            OP_SRA:   alu_result = $signed(op_b) >>> shift_amount;
            OP_SLLV:  alu_result = op_b << var_sh;
            OP_SRLV:  alu_result = op_b >> var_sh;
            OP_SRAV:  alu_result = $signed(op_b) >>> var_sh;
            OP_LUI:   alu_result = {op_b[15:0], 16'h0};
            OP_MFHI:  alu_result = hi_q;
            OP_MFLO:  alu_result = lo_q;
            OP_PASSA: alu_result = op_a;
            default:  alu_result = 32'h0;
        endcase
    end

    // Division runs at 64 bits so the 0x80000000 / -1 case wraps instead of trapping.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        case (alu_control)
            OP_MULT:  {hi_d, lo_d} = a_s64 * b_s64;
            OP_MULTU: {hi_d, lo_d} = a_u64 * b_u64;
            OP_DIV: begin
                if (op_b != 32'h0) begin
                    lo_d = 32'(a_s64 / b_s64);
                    hi_d = 32'(a_s64 % b_s64);
                end
            end
            OP_DIVU: begin
                if (op_b != 32'h0) begin
                    lo_d = op_a / op_b;
                    hi_d = op_a % op_b;
                end
            end
            OP_MTHI:  hi_d = op_a;
            OP_MTLO:  lo_d = op_a;
            default: begin
                hi_d = hi_q;
                lo_d = lo_q;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            hi_q <= 32'h0;
            lo_q <= 32'h0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

    always_comb begin
        taken = 1'b0;
        if (jump) begin
            taken = 1'b1;
        end else begin
            case (opcode)
                6'h04: taken = (op_a == op_b);
                6'h05: taken = (op_a != op_b);
                6'h06: taken = op_a[31] || (op_a == 32'h0);
                6'h07: taken = !op_a[31] && (op_a != 32'h0);
                6'h01: begin
                    case (rt)
                        5'h00, 5'h10: taken = op_a[31];
                        5'h01, 5'h11: taken = !op_a[31];
                        default:      taken = 1'b0;
                    endcase
                end
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_alu_branch_unit.sv
// Self-checking bench for exe_alu_branch_unit: directed vector table, HI/LO
// sequences, and random stimulus against a behavioural model.
module tb_exe_alu_branch_unit;

    logic        CLK;
    logic        RESET;
    logic [31:0] op_a, op_b, instr;
    logic [5:0]  alu_control;
    logic [4:0]  shift_amount;
    logic        jump;
    logic [31:0] alu_result, hi, lo;
    logic        taken;

    int checks   = 0;
    int failures = 0;

    exe_alu_branch_unit dut (
        .CLK(CLK), .RESET(RESET), .op_a(op_a), .op_b(op_b),
        .alu_control(alu_control), .shift_amount(shift_amount),
        .instr(instr), .jump(jump), .alu_result(alu_result),
        .hi(hi), .lo(lo), .taken(taken)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  ctrl;
        logic [4:0]  sh;
        logic [31:0] ins;
        logic        j;
        logic [31:0] exp_result;
        logic        exp_taken;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c,
                                 input logic [4:0] s, input logic [31:0] ins, input logic j);
        op_a = a; op_b = b; alu_control = c; shift_amount = s; instr = ins; jump = j;
    endtask

    task automatic stepEdge();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Reference model: MIPS semantics written directly as integer arithmetic.
    function automatic logic [31:0] modelResult(input logic [31:0] a, input logic [31:0] b,
                                                input logic [5:0] c, input logic [4:0] s,
                                                input logic [31:0] mhi, input logic [31:0] mlo);
        int sa = int'(a);
        int sb = int'(b);
        case (c)
            6'h01: return a + b;
            6'h02: return a - b;
            6'h03: return a & b;
            6'h04: return a | b;
            6'h05: return a ^ b;
            6'h06: return ~(a | b);
            6'h07: return (sa < sb) ? 32'd1 : 32'd0;
            6'h08: return (a < b) ? 32'd1 : 32'd0;
            6'h09: return b << s;
            6'h0A: return b >> s;
            6'h0B: return 32'(sb >>> s);
            6'h0C: return b << (a % 32);
            6'h0D: return b >> (a % 32);
            6'h0E: return 32'(sb >>> (a % 32));
            6'h0F: return b * 32'h10000;
            6'h14: return mhi;
            6'h15: return mlo;
            6'h18: return a;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic modelTaken(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] ins, input logic j);
        int sa = int'(a);
        int unsigned opc = ins / 32'h0400_0000;
        int unsigned rtf = (ins / 32'h1_0000) % 32;
        if (j) return 1'b1;
        case (opc)
            4: return a == b;
            5: return a != b;
            6: return sa <= 0;
            7: return sa > 0;
            1: begin
                if (rtf == 0 || rtf == 16) return sa < 0;
                if (rtf == 1 || rtf == 17) return sa >= 0;
                return 1'b0;
            end
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelHiLo(input logic [31:0] a, input logic [31:0] b, input logic [5:0] c,
                             inout logic [31:0] mhi, inout logic [31:0] mlo);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        longint q;
        longint unsigned p;
        case (c)
            6'h10: begin p = longint'(sa * sb); mhi = p[63:32]; mlo = p[31:0]; end
            6'h11: begin p = longint'(a) * longint'(b); mhi = p[63:32]; mlo = p[31:0]; end
            6'h12: if (b != 0) begin
                q = sa / sb;
                mlo = 32'(q);
                mhi = 32'(sa - q * sb);
            end
            6'h13: if (b != 0) begin mlo = a / b; mhi = a % b; end
            6'h16: mhi = a;
            6'h17: mlo = a;
            default: ;
        endcase
    endtask

    logic [31:0] mhi, mlo;

    initial begin
        RESET = 1'b0;
        applyStimulus(0, 0, 6'h00, 0, 0, 0);

        vecs.push_back('{"add_wrap",  32'h7FFFFFFF, 32'h1, 6'h01, 5'd0, 32'h0, 1'b0, 32'h80000000, 1'b0});
        vecs.push_back('{"sub_wrap",  32'h0, 32'h1, 6'h02, 5'd0, 32'h0, 1'b0, 32'hFFFFFFFF, 1'b0});
        vecs.push_back('{"and",       32'hF0F0_1234, 32'h0FF0_FF00, 6'h03, 5'd0, 32'h0, 1'b0, 32'h00F0_1200, 1'b0});
        vecs.push_back('{"or",        32'hF000_0001, 32'h0000_0F00, 6'h04, 5'd0, 32'h0, 1'b0, 32'hF000_0F01, 1'b0});
        vecs.push_back('{"xor",       32'hFFFF_0000, 32'hFF00_FF00, 6'h05, 5'd0, 32'h0, 1'b0, 32'h00FF_FF00, 1'b0});
        vecs.push_back('{"nor",       32'hFFFF_0000, 32'h0000_00FF, 6'h06, 5'd0, 32'h0, 1'b0, 32'h0000_FF00, 1'b0});
        vecs.push_back('{"slt",       32'hFFFFFFFF, 32'h1, 6'h07, 5'd0, 32'h0, 1'b0, 32'h1, 1'b0});
        vecs.push_back('{"sltu",      32'hFFFFFFFF, 32'h1, 6'h08, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"sll",       32'h0, 32'h0000_0003, 6'h09, 5'd31, 32'h0, 1'b0, 32'h8000_0000, 1'b0});
        vecs.push_back('{"srl",       32'h0, 32'h8000_0000, 6'h0A, 5'd4, 32'h0, 1'b0, 32'h0800_0000, 1'b0});
        vecs.push_back('{"sra",       32'h0, 32'h8000_0000, 6'h0B, 5'd4, 32'h0, 1'b0, 32'hF800_0000, 1'b0});
        vecs.push_back('{"sllv",      32'h0000_0021, 32'h1, 6'h0C, 5'd0, 32'h0, 1'b0, 32'h2, 1'b0});
        vecs.push_back('{"srlv",      32'h24, 32'h8000_0000, 6'h0D, 5'd0, 32'h0, 1'b0, 32'h0800_0000, 1'b0});
        vecs.push_back('{"srav",      32'h8, 32'h8000_0000, 6'h0E, 5'd0, 32'h0, 1'b0, 32'hFF80_0000, 1'b0});
        vecs.push_back('{"lui",       32'h0, 32'h1234, 6'h0F, 5'd0, 32'h0, 1'b0, 32'h1234_0000, 1'b0});
        vecs.push_back('{"passa",     32'hDEAD_BEEF, 32'h5, 6'h18, 5'd0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"unused3f",  32'h1234_5678, 32'h5, 6'h3F, 5'd3, 32'h0, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"beq",       32'h5, 32'h5, 6'h00, 5'd0, 32'h1000_0000, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{"bne",       32'h5, 32'h5, 6'h00, 5'd0, 32'h1400_0000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"blez0",     32'h0, 32'h0, 6'h00, 5'd0, 32'h1800_0000, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{"bgtz0",     32'h0, 32'h0, 6'h00, 5'd0, 32'h1C00_0000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"bgezal",    32'h8000_0000, 32'h0, 6'h00, 5'd0, 32'h0411_0000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"bltzal",    32'h8000_0000, 32'h0, 6'h00, 5'd0, 32'h0410_0000, 1'b0, 32'h0, 1'b1});
        vecs.push_back('{"lw_nojump", 32'h5, 32'h5, 6'h00, 5'd0, 32'h8C00_0000, 1'b0, 32'h0, 1'b0});
        vecs.push_back('{"lw_jump",   32'h5, 32'h5, 6'h01, 5'd0, 32'h8C00_0000, 1'b1, 32'hA, 1'b1});

        @(negedge CLK);
        checkOutput("reset_hi", hi, 32'h0);
        checkOutput("reset_lo", lo, 32'h0);
        @(negedge CLK);
        RESET = 1'b1;
        applyStimulus(0, 0, 6'h14, 0, 0, 0);
        #1 checkOutput("mfhi_after_reset", alu_result, 32'h0);
        applyStimulus(0, 0, 6'h15, 0, 0, 0);
        #1 checkOutput("mflo_after_reset", alu_result, 32'h0);
        @(negedge CLK);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].ctrl, vecs[i].sh, vecs[i].ins, vecs[i].j);
            #1;
            checkOutput({vecs[i].name, "_result"}, alu_result, vecs[i].exp_result);
            checkOutput({vecs[i].name, "_taken"}, {31'h0, taken}, {31'h0, vecs[i].exp_taken});
            @(negedge CLK);
        end

        applyStimulus(32'hFFFFFFFE, 32'h3, 6'h10, 0, 0, 0);
        #1 checkOutput("mult_result", alu_result, 32'h0);
        stepEdge();
        checkOutput("mult_hi", hi, 32'hFFFFFFFF);
        checkOutput("mult_lo", lo, 32'hFFFFFFFA);
        applyStimulus(0, 0, 6'h15, 0, 0, 0);
        #1 checkOutput("mflo_after_mult", alu_result, 32'hFFFFFFFA);
        applyStimulus(32'hFFFFFFFE, 32'h3, 6'h11, 0, 0, 0);
        stepEdge();
        checkOutput("multu_hi", hi, 32'h2);
        checkOutput("multu_lo", lo, 32'hFFFFFFFA);

        applyStimulus(32'hFFFFFFF9, 32'h2, 6'h12, 0, 0, 0);
        stepEdge();
        checkOutput("div_hi", hi, 32'hFFFFFFFF);
        checkOutput("div_lo", lo, 32'hFFFFFFFD);
        applyStimulus(32'h1234, 32'h0, 6'h12, 0, 0, 0);
        stepEdge();
        checkOutput("div0_hi", hi, 32'hFFFFFFFF);
        checkOutput("div0_lo", lo, 32'hFFFFFFFD);
        applyStimulus(32'h1234, 32'h0, 6'h13, 0, 0, 0);
        stepEdge();
        checkOutput("divu0_lo", lo, 32'hFFFFFFFD);
        applyStimulus(32'h1234, 32'h77, 6'h3F, 0, 0, 0);
        stepEdge();
        checkOutput("unused_hi_hold", hi, 32'hFFFFFFFF);
        checkOutput("unused_lo_hold", lo, 32'hFFFFFFFD);

        applyStimulus(32'h0000_1234, 0, 6'h17, 0, 0, 0);
        #2 RESET = 1'b0;
        #1;
        checkOutput("async_reset_hi", hi, 32'h0);
        checkOutput("async_reset_lo", lo, 32'h0);
        stepEdge();
        checkOutput("reset_hold_lo", lo, 32'h0);
        RESET = 1'b1;
        stepEdge();
        checkOutput("post_reset_mtlo", lo, 32'h0000_1234);
        applyStimulus(32'hCAFE_0000, 0, 6'h16, 0, 0, 0);
        stepEdge();
        checkOutput("mthi", hi, 32'hCAFE_0000);

        mhi = hi;
        mlo = lo;
        for (int n = 0; n < 400; n++) begin
            logic [31:0] a, b, ins;
            logic [5:0]  c;
            logic [4:0]  s;
            logic        j;
            int unsigned pick;
            a = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : $urandom;
            b = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = a;
            c = ($urandom_range(0, 15) == 0) ? 6'($urandom) : 6'($urandom_range(0, 24));
            s = 5'($urandom);
            pick = $urandom_range(0, 7);
            case (pick)
                0: ins = {6'h04, 26'($urandom)};
                1: ins = {6'h05, 26'($urandom)};
                2: ins = {6'h06, 26'($urandom)};
                3: ins = {6'h07, 26'($urandom)};
                4, 5: ins = {6'h01, 5'($urandom), 5'($urandom_range(0, 1) ? $urandom_range(0, 1) : $urandom_range(16, 17)), 16'($urandom)};
                default: ins = $urandom;
            endcase
            j = ($urandom_range(0, 7) == 0);
            applyStimulus(a, b, c, s, ins, j);
            #1;
            checkOutput("rand_result", alu_result, modelResult(a, b, c, s, mhi, mlo));
            checkOutput("rand_taken", {31'h0, taken}, {31'h0, modelTaken(a, b, ins, j)});
            modelHiLo(a, b, c, mhi, mlo);
            stepEdge();
            checkOutput("rand_hi", hi, mhi);
            checkOutput("rand_lo", lo, mlo);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
